// File: rtl/fir_pkg.sv
// Shared definitions for the FIR coefficient path: loader state encoding,
// counter sizing and the tap-slice convention (tap j at [(N-1-j)*W +: W]).
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } fir_state_t;

  // Counter must hold the values 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // LSB of the slice that holds tap j (0-based arrival order); first tap is MSB.
  function automatic int tap_lsb(input int j, input int n, input int w);
    return (n - 1 - j) * w;
  endfunction

endpackage

// File: rtl/fir_coeff_loader.sv
// Streams FIR taps into a shadow bank and commits whole sets atomically.
// Optional idle timeout in LOAD/DRAIN: define FIR_COEFF_LOADER_TIMEOUT_EN.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int N           = 4,
  parameter int COEFF_WIDTH = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COEFF_WIDTH-1:0]   coeff_in,
  input  logic                     coeff_valid,
  input  logic                     coeff_last,
  output logic                     coeff_ready,
  output logic [N*COEFF_WIDTH-1:0] packed_coeffs,
  output logic                     coeffs_update,
  output logic                     load_error,
  output logic                     busy,
  output logic [1:0]               state_dbg
);

  // Handshake: a beat transfers on a rising edge where coeff_valid && coeff_ready;
  // the sender holds coeff_in/coeff_last stable until then. Ready drops only
  // during the single COMMIT cycle and while rst is high.

  localparam int CW = cnt_width(N);
  localparam int PW = N * COEFF_WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  fir_state_t    state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] shadow;
  logic          accept;
  logic          timed_out;

  assign coeff_ready = !rst && (state != COMMIT);
  assign busy        = !rst && (state != IDLE);
  assign accept      = coeff_valid && coeff_ready;
  assign state_dbg   = state;

`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] idle_cnt;

  // Fires on the edge where the idle count would reach TIMEOUT.
  assign timed_out = ((state == LOAD) || (state == DRAIN)) && !accept &&
                     (idle_cnt == IDLE_LIMIT);

  always_ff @(posedge clk) begin
    if (rst || accept || timed_out || !((state == LOAD) || (state == DRAIN))) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  // Without the counter the loader waits forever; TIMEOUT has no effect.
  assign timed_out = 1'b0 && (TIMEOUT < 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      shadow        <= '0;
      packed_coeffs <= '0;
      coeffs_update <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      coeffs_update <= 1'b0;
      load_error    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            shadow[PW-1 -: COEFF_WIDTH] <= coeff_in;
            cnt                         <= CW'(1);
            if (coeff_last && (N > 1)) begin
              load_error <= 1'b1;
            end else if (coeff_last) begin
              state <= COMMIT;
            end else if (N == 1) begin
              state <= DRAIN;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (timed_out) begin
            load_error <= 1'b1;
            shadow     <= '0;
            cnt        <= '0;
            state      <= IDLE;
          end else if (accept) begin
            for (int j = 1; j < N; j++) begin
              if (cnt == CW'(j)) shadow[tap_lsb(j, N, COEFF_WIDTH) +: COEFF_WIDTH] <= coeff_in;
            end
            cnt <= cnt + 1'b1;
            if (cnt == LAST_CNT) begin
              state <= coeff_last ? COMMIT : DRAIN;
            end else if (coeff_last) begin
              load_error <= 1'b1;
              cnt        <= '0;
              state      <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (timed_out || (accept && coeff_last)) begin
            load_error <= 1'b1;
            cnt        <= '0;
            state      <= IDLE;
          end
        end
        COMMIT: begin
          packed_coeffs <= shadow;
          coeffs_update <= 1'b1;
          cnt           <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed timing sequences, a vector table and
// randomized sets scored against a set-level reference model.
module tb_fir_coeff_loader;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int PW = N * W;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  coeff_in = '0;
  logic          coeff_valid = 1'b0;
  logic          coeff_last = 1'b0;
  logic          coeff_ready;
  logic [PW-1:0] packed_coeffs;
  logic          coeffs_update;
  logic          load_error;
  logic          busy;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;
  int err_cnt  = 0;
  bit sb_on    = 1'b0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] model_packed;
  logic [W-1:0]  set_buf[8];
  int            set_len;

  typedef struct {
    int          len;
    int          gap;
    logic [47:0] taps;
    bit          exp_upd;
    logic [31:0] exp_packed;
  } vec_t;
  vec_t vecs[7];

  fir_coeff_loader #(.N(N), .COEFF_WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .coeff_in(coeff_in), .coeff_valid(coeff_valid),
    .coeff_last(coeff_last), .coeff_ready(coeff_ready), .packed_coeffs(packed_coeffs),
    .coeffs_update(coeffs_update), .load_error(load_error), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [PW-1:0] sb_exp;
  always @(negedge clk) begin
    if (coeffs_update) begin
      upd_cnt++;
      check("update_excl_error", 64'(load_error), 64'd0);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          check("unexpected_update", 64'(packed_coeffs), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_packed", 64'(packed_coeffs), 64'(sb_exp));
        end
      end
    end
    if (load_error) err_cnt++;
  end

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; returns just after the falling edge
  // that follows the accepting rising edge, with the beat still driven.
  task automatic send_beat(input logic [W-1:0] d, input logic l);
    coeff_valid = 1'b1;
    coeff_in    = d;
    coeff_last  = l;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (coeff_ready) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("beat_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_set(input int gap, input bit rand_gap);
    int g;
    for (int i = 0; i < set_len; i++) begin
      send_beat(set_buf[i], (i == set_len - 1));
      g = rand_gap ? int'($urandom_range(0, gap)) : gap;
      if (i < set_len - 1 && g > 0) begin
        coeff_valid = 1'b0;
        repeat (g) @(negedge clk);
      end
    end
  endtask

  task automatic settle();
    coeff_valid = 1'b0;
    coeff_last  = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Reference: a set commits only if it has exactly N taps; first tap is MSB.
  function automatic logic [PW-1:0] concat_model();
    logic [PW-1:0] v = '0;
    for (int j = 0; j < N; j++) v = (v << W) | PW'(set_buf[j]);
    return v;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int ub, eb, exp_err;
    logic [47:0] t;

    vecs[0] = '{len:4, gap:0, taps:48'h0A0B0C0D_0000, exp_upd:1'b1, exp_packed:32'h0A0B0C0D};
    vecs[1] = '{len:6, gap:0, taps:48'h010203040506, exp_upd:1'b0, exp_packed:32'h0A0B0C0D};
    vecs[2] = '{len:4, gap:1, taps:48'h807F00FF_0000, exp_upd:1'b1, exp_packed:32'h807F00FF};
    vecs[3] = '{len:1, gap:0, taps:48'h550000000000, exp_upd:1'b0, exp_packed:32'h807F00FF};
    vecs[4] = '{len:3, gap:1, taps:48'h112233000000, exp_upd:1'b0, exp_packed:32'h807F00FF};
    vecs[5] = '{len:5, gap:2, taps:48'hA1A2A3A4A500, exp_upd:1'b0, exp_packed:32'h807F00FF};
    vecs[6] = '{len:4, gap:2, taps:48'hDEADBEEF_0000, exp_upd:1'b1, exp_packed:32'hDEADBEEF};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(coeff_ready), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_packed", 64'(packed_coeffs), 64'd0);
    check("rst_update", 64'(coeffs_update), 64'd0);
    check("rst_error", 64'(load_error), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(coeff_ready), 64'd1);
    check("post_rst_state", 64'(state_dbg), 64'd0);

    // Nominal set with commit timing
    send_beat(8'h04, 1'b0);
    send_beat(8'h03, 1'b0);
    send_beat(8'hFF, 1'b0);
    send_beat(8'hFE, 1'b1);
    check("commit_ready_low", 64'(coeff_ready), 64'd0);
    check("commit_busy", 64'(busy), 64'd1);
    check("commit_no_update_yet", 64'(coeffs_update), 64'd0);
    check("commit_packed_old", 64'(packed_coeffs), 64'd0);
    coeff_valid = 1'b0;
    @(negedge clk);
    check("t2_update", 64'(coeffs_update), 64'd1);
    check("t2_packed", 64'(packed_coeffs), 64'h0403FFFE);
    check("t2_ready", 64'(coeff_ready), 64'd1);
    check("t2_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    check("update_one_cycle", 64'(coeffs_update), 64'd0);

    // Early last
    send_beat(8'h07, 1'b0);
    send_beat(8'h05, 1'b1);
    check("early_err_pulse", 64'(load_error), 64'd1);
    check("early_state_idle", 64'(state_dbg), 64'd0);
    coeff_valid = 1'b0;
    @(negedge clk);
    check("early_err_one_cycle", 64'(load_error), 64'd0);
    check("early_packed_kept", 64'(packed_coeffs), 64'h0403FFFE);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      ub = upd_cnt;
      eb = err_cnt;
      set_len = vecs[i].len;
      t = vecs[i].taps;
      for (int j = 0; j < 6; j++) set_buf[j] = t[47-8*j -: 8];
      send_set(vecs[i].gap, 1'b0);
      settle();
      check($sformatf("vec%0d_updates", i), 64'(upd_cnt - ub), 64'(vecs[i].exp_upd));
      check($sformatf("vec%0d_errors", i), 64'(err_cnt - eb), 64'(!vecs[i].exp_upd));
      check($sformatf("vec%0d_packed", i), 64'(packed_coeffs), 64'(vecs[i].exp_packed));
    end

    // Reset mid-load
    ub = upd_cnt;
    send_beat(8'h77, 1'b0);
    send_beat(8'h66, 1'b0);
    coeff_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(coeff_ready), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_packed", 64'(packed_coeffs), 64'd0);
    check("midrst_state", 64'(state_dbg), 64'd0);
    set_len = 4;
    for (int j = 0; j < 4; j++) set_buf[j] = 8'(j + 1);
    send_set(0, 1'b0);
    settle();
    check("midrst_one_update", 64'(upd_cnt - ub), 64'd1);
    check("midrst_fresh_set", 64'(packed_coeffs), 64'h01020304);
    model_packed = 32'h01020304;

`ifdef FIR_COEFF_LOADER_TIMEOUT_EN
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    coeff_valid = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check($sformatf("timeout_err_idle%0d", k), 64'(load_error), 64'(k == TO));
    end
    check("timeout_state_idle", 64'(state_dbg), 64'd0);
    check("timeout_packed_kept", 64'(packed_coeffs), 64'(model_packed));
`else
    eb = err_cnt;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    coeff_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("no_timeout_state", 64'(state_dbg), 64'd1);
    check("no_timeout_errors", 64'(err_cnt - eb), 64'd0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    settle();
    model_packed = 32'h11223344;
    check("resume_packed", 64'(packed_coeffs), 64'(model_packed));
`endif

    // Randomized sets against the set-level model
    sb_on   = 1'b1;
    eb      = err_cnt;
    exp_err = 0;
    for (int s = 0; s < 40; s++) begin
      set_len = int'($urandom_range(1, 6));
      for (int j = 0; j < set_len; j++) set_buf[j] = 8'($urandom_range(0, 255));
      if (set_len == N) begin
        model_packed = concat_model();
        exp_q.push_back(model_packed);
      end else begin
        exp_err++;
      end
      send_set(int'($urandom_range(0, 2)), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        coeff_valid = 1'b0;
        @(negedge clk);
      end
    end
    settle();
    check("rand_errors", 64'(err_cnt - eb), 64'(exp_err));
    check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
    check("rand_final_packed", 64'(packed_coeffs), 64'(model_packed));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Coefficient-side writer for the FIR filter: accepts taps one at a time over a valid/ready stream, assembles them in a shadow bank, and commits the full set atomically onto the filter's `packed_coeffs` bus. It sits between the control/register path and the FIR. The filter therefore never sees a partially updated tap set.

## Interface
- `N`, 4: number of taps.
- `COEFF_WIDTH`, 8: signed tap width, two's complement.
- `TIMEOUT`, 255: idle-cycle limit for the timeout feature; must be ≥ 1.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: reset; synchronous and active-high.
- `coeff_in`  in  COEFF_WIDTH: tap value.
- `coeff_valid`  in  1: `coeff_in` and `coeff_last` are valid.
- `coeff_last`  in  1: marks the final tap of a set.
- `coeff_ready`  out  1: loader can accept a beat.
- `packed_coeffs`  out  N*COEFF_WIDTH: active tap set driven to the FIR.
- `coeffs_update`  out  1: one-cycle pulse in the first cycle a new set is active.
- `load_error`  out  1: one-cycle pulse when a set is rejected.
- `busy`  out  1: a set is partially received or being committed.

## Operation
- A beat is accepted on a rising edge where `coeff_valid && coeff_ready`.
- Packing: the first accepted tap of a set lands in bits [N*W-1 -: W], i.e. MSB first. Tap j (0-based arrival order) goes to slice (N-1-j). The stream order therefore matches writing the concatenation left to right.
- States:
  - IDLE: ready=1, busy=0. An accepted beat writes shadow slice N-1 and sets cnt=1. If that beat has last=1 and N>1, raise error and stay in IDLE. Otherwise go to LOAD, or to COMMIT when N=1 and last=1.
  - LOAD: ready=1, busy=1. Each accepted beat writes slice N-1-cnt and increments cnt.
    - Beat N with last=1: go to COMMIT.
    - Beat N with last=0: go to DRAIN.
    - Beat < N with last=1: raise error, go to IDLE.
  - DRAIN: ready=1, busy=1. Accepted beats are discarded. The beat with last=1 raises error and returns to IDLE.
  - COMMIT: ready=0, busy=1, lasts exactly one cycle. On the exiting edge, `packed_coeffs <= shadow` and `coeffs_update <= 1`. Next state is IDLE.
- `packed_coeffs` changes only on a COMMIT exit or on reset. Rejected sets never reach it.
- `coeff_valid` with ready=0 is ignored. The sender must hold the beat until ready.
- Reset values (while `rst` is high and on the edge it is sampled):
  - state=IDLE, cnt=0, shadow=0.
  - `packed_coeffs`=0, `coeffs_update`=0, `load_error`=0.
  - `coeff_ready`=0 (gated by `rst`), `busy`=0.
- Reset mid-load or mid-commit: the partial set is discarded, `packed_coeffs` returns to 0, and no update pulse is issued.
- Taps are stored bit-exact. There is no sign extension or scaling.

## Timing
- Beat N accepted at edge t. Cycle t+1 is COMMIT with ready=0. Cycle t+2 shows the new `packed_coeffs`, `coeffs_update`=1, state IDLE and ready=1.
- Throughput: N+1 cycles per set when `coeff_valid` is held continuously.
- `load_error` is registered and is high in the cycle after the offending beat is accepted.
- `coeffs_update` and `load_error` are never high together. Each is high for exactly one cycle per event.
- Back-to-back sets: the first beat of the next set may be accepted in cycle t+2.

## Configuration
- `FIR_COEFF_LOADER_TIMEOUT_EN`
  - Defined: in LOAD or DRAIN, an idle counter increments on every cycle with no accepted beat and clears on each accepted beat. When it reaches TIMEOUT, the set is aborted: `load_error` pulses, the shadow is discarded, state goes to IDLE and the counter clears.
  - Undefined: there is no counter, and LOAD/DRAIN wait indefinitely. `TIMEOUT` is ignored.

## Structure
- Shared package `fir_pkg` holds:
  - state encoding localparams IDLE/LOAD/DRAIN/COMMIT, 2 bits;
  - the cnt width rule, $clog2(N+1);
  - the slice-index helper convention, tap j at [(N-1-j)*W +: W].
- No sub-module: the FSM, shadow register and optional timeout counter stay in one module.

## Test plan
- Reset release, then taps 4, 3, -1, -2 with last on the 4th → `packed_coeffs`=0x0403FFFE in cycle t+2, `coeffs_update` high one cycle, ready low only in the COMMIT cycle.
- Early last: 7, 5 with last on the 2nd → `load_error` pulse, `packed_coeffs` unchanged at 0x0403FFFE, next full set accepted normally.
- Overlong set of six taps, last on the 6th → DRAIN consumes taps 5–6, one `load_error`, `packed_coeffs` unchanged.
- `coeff_valid` toggling 1,0,1,0 during a load, including valid asserted during COMMIT → beats are accepted only when ready=1, and the committed set equals the accepted sequence.
- `rst` pulsed after two taps of a set → `packed_coeffs`=0, no `coeffs_update`; a fresh set 1, 2, 3, 4 then yields 0x01020304.
- With `FIR_COEFF_LOADER_TIMEOUT_EN` and TIMEOUT=8: two taps then 8 idle cycles → `load_error` at the 8th idle cycle, state IDLE, `packed_coeffs` unchanged.
